// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage plus fetch/decode pipeline register.
//            Owns the PC and keeps at most one request outstanding to
//            instruction memory. Redirects squash the in-flight fetch, and a
//            response that arrives while decode is stalled is parked in a
//            one-entry hold buffer.
// Revision : 1.0 - initial release
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched/perf_squashed)
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   pc_select/pc_target : redirect request and target from execute
//   stall               : hold the fetch/decode register
//   flush_fetch_decode  : invalidate the fetch/decode register
//   imem_req_*          : request channel (valid/ready, byte address)
//   imem_rsp_*          : response channel (valid, instruction word)
//   fd_*                : fetch/decode register contents presented to decode
//   perf_fetched        : responses loaded into fd_* or the hold buffer
//   perf_squashed       : responses discarded plus valid fd_* entries flushed
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_select,
  input  logic [31:0] pc_target,
  input  logic        stall,
  input  logic        flush_fetch_decode,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fd_valid,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] redir_pc;
  logic        hold_valid;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        req_fire;
  logic        rsp_take;
  logic        to_hold;
  logic        to_fd;

  // Requests are suppressed while reset is asserted, while a stalled
  // response is parked, and in the cycle a redirect arrives so the address
  // can switch without a handshake on the stale PC.
  assign imem_req_valid = rst_n && (state == ST_REQ) && !hold_valid && !pc_select;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only if it belongs to a live request.
  assign rsp_take = (state == ST_WAIT) && imem_rsp_valid && !pc_select;
  // Decode is holding a real instruction: the new one must wait aside.
  assign to_hold  = rsp_take && stall && fd_valid;
  assign to_fd    = rsp_take && !(stall && fd_valid) && !flush_fetch_decode;

  // --------------------------------------------------------------------------
  // Request state machine and PC
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      redir_pc <= RESET_PC;
    end else begin
      case (state)
        ST_REQ: begin
          if (pc_select) begin
            pc <= pc_target;
          end else if (req_fire) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (pc_select) begin
              pc <= pc_target;
            end
            state <= ST_REQ;
          end else if (pc_select) begin
            // The response is still owed by memory; remember where to go
            // once it has been swallowed.
            redir_pc <= pc_target;
            state    <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (imem_rsp_valid) begin
            pc    <= pc_select ? pc_target : redir_pc;
            state <= ST_REQ;
          end else if (pc_select) begin
            redir_pc <= pc_target;
          end
        end
        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Hold buffer: drains on the first unstalled, unflushed cycle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= '0;
    end else if (pc_select) begin
      hold_valid <= 1'b0;
    end else if (to_hold) begin
      hold_valid <= 1'b1;
      hold_instr <= imem_rsp_data;
      hold_pc    <= req_pc;
    end else if (hold_valid && !stall && !flush_fetch_decode) begin
      hold_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch/decode register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fd_valid    <= 1'b0;
      fd_instr    <= NOP_INSTR;
      fd_pc       <= '0;
      fd_pc_plus4 <= 32'd4;
    end else if (flush_fetch_decode || pc_select) begin
      fd_valid <= 1'b0;
      fd_instr <= NOP_INSTR;
    end else if (!stall && hold_valid) begin
      fd_valid    <= 1'b1;
      fd_instr    <= hold_instr;
      fd_pc       <= hold_pc;
      fd_pc_plus4 <= hold_pc + 32'd4;
    end else if (to_fd) begin
      // Also taken under stall when decode holds only a bubble.
      fd_valid    <= 1'b1;
      fd_instr    <= imem_rsp_data;
      fd_pc       <= req_pc;
      fd_pc_plus4 <= req_pc + 32'd4;
    end else if (!stall) begin
      fd_valid <= 1'b0;
      fd_instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  logic rsp_discard;
  logic rsp_lost;
  logic fd_flushed;

  assign rsp_discard = imem_rsp_valid &&
                       (((state == ST_WAIT) && pc_select) || (state == ST_DROP));
  // A response coinciding with a flush that has nowhere else to go.
  assign rsp_lost    = rsp_take && flush_fetch_decode && !to_hold;
  assign fd_flushed  = flush_fetch_decode && fd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      perf_fetched  <= perf_fetched + {31'd0, (to_fd || to_hold)};
      perf_squashed <= perf_squashed + {31'd0, rsp_discard}
                                     + {31'd0, rsp_lost}
                                     + {31'd0, fd_flushed};
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A per-cycle vector table
//            drives the control inputs while a small memory model answers
//            accepted requests with addr ^ 32'hA5A5_0000 after a per-request
//            latency; hand sequences cover reset values and mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam int          NV  = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_select;
  logic [31:0] pc_target;
  logic        stall;
  logic        flush_fetch_decode;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic [31:0] fd_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pc_select          (pc_select),
    .pc_target          (pc_target),
    .stall              (stall),
    .flush_fetch_decode (flush_fetch_decode),
    .imem_req_valid     (imem_req_valid),
    .imem_req_addr      (imem_req_addr),
    .imem_req_ready     (imem_req_ready),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .fd_valid           (fd_valid),
    .fd_instr           (fd_instr),
    .fd_pc              (fd_pc),
    .fd_pc_plus4        (fd_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched       (perf_fetched),
    .perf_squashed      (perf_squashed)
`endif
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        sel;
    logic [31:0] target;
    logic        ready;
    int          lat;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_fv;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state: one outstanding request.
  logic        mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  int          cur_lat  = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; memory answers after the programmed latency.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      mem_pend = 1'b1;
      mem_cnt  = cur_lat;
      mem_addr = a;
    end
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_addr ^ KEY;
        mem_pend       = 1'b0;
      end
    end
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic sl,
                              input logic [31:0] tg, input logic rdy, input int lat,
                              input logic rv, input logic [31:0] ra,
                              input logic fv, input logic [31:0] pc,
                              input logic [31:0] ins);
    vec_t v;
    v.stall = st; v.flush = fl; v.sel = sl; v.target = tg; v.ready = rdy; v.lat = lat;
    v.e_rv = rv; v.e_ra = ra; v.e_fv = fv; v.e_pc = pc; v.e_ins = ins;
    return v;
  endfunction

  initial begin
    //              st fl sl target        rdy lat | rv addr          fv pc            instr
    vecs[0]  = mk(0, 0, 0, 32'h0,        1, 1,   1, 32'h0,        0, 32'h0,        NOP);
    vecs[1]  = mk(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,        0, 32'h0,        NOP);
    vecs[2]  = mk(0, 0, 0, 32'h0,        1, 1,   1, 32'h4,        1, 32'h0,        32'hA5A5_0000);
    vecs[3]  = mk(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,        0, 32'h0,        NOP);
    vecs[4]  = mk(0, 0, 0, 32'h0,        1, 1,   1, 32'h8,        1, 32'h4,        32'hA5A5_0004);
    vecs[5]  = mk(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,        0, 32'h4,        NOP);
    // stall for three cycles across the WAIT response
    vecs[6]  = mk(1, 0, 0, 32'h0,        1, 1,   1, 32'hC,        1, 32'h8,        32'hA5A5_0008);
    vecs[7]  = mk(1, 0, 0, 32'h0,        1, 1,   0, 32'h0,        1, 32'h8,        32'hA5A5_0008);
    vecs[8]  = mk(1, 0, 0, 32'h0,        1, 1,   0, 32'h0,        1, 32'h8,        32'hA5A5_0008);
    vecs[9]  = mk(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,        1, 32'h8,        32'hA5A5_0008);
    vecs[10] = mk(0, 0, 0, 32'h0,        1, 1,   1, 32'h10,       1, 32'hC,        32'hA5A5_000C);
    // redirect coincident with the WAIT response
    vecs[11] = mk(0, 0, 1, 32'h200,      1, 1,   0, 32'h0,        0, 32'hC,        NOP);
    vecs[12] = mk(0, 0, 0, 32'h0,        0, 1,   1, 32'h200,      0, 32'hC,        NOP);
    // redirect in REQ with ready low
    vecs[13] = mk(0, 0, 1, 32'h300,      0, 1,   0, 32'h0,        0, 32'hC,        NOP);
    vecs[14] = mk(0, 0, 0, 32'h0,        1, 2,   1, 32'h300,      0, 32'hC,        NOP);
    // redirect in WAIT, response two cycles after acceptance
    vecs[15] = mk(0, 0, 1, 32'h100,      1, 1,   0, 32'h0,        0, 32'hC,        NOP);
    vecs[16] = mk(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,        0, 32'hC,        NOP);
    vecs[17] = mk(0, 0, 0, 32'h0,        1, 1,   1, 32'h100,      0, 32'hC,        NOP);
    vecs[18] = mk(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,        0, 32'hC,        NOP);
    // redirect to the top word to exercise wrap-around
    vecs[19] = mk(0, 0, 1, 32'hFFFF_FFFC, 1, 1,  0, 32'h0,        1, 32'h100,      32'hA5A5_0100);
    vecs[20] = mk(0, 0, 0, 32'h0,        1, 1,   1, 32'hFFFF_FFFC, 0, 32'h100,     NOP);
    vecs[21] = mk(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,        0, 32'h100,      NOP);
    // flush together with stall while fd holds a valid instruction
    vecs[22] = mk(1, 1, 0, 32'h0,        1, 1,   1, 32'h0,        1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
    vecs[23] = mk(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,        0, 32'hFFFF_FFFC, NOP);
    vecs[24] = mk(0, 0, 0, 32'h0,        1, 1,   1, 32'h4,        1, 32'h0,        32'hA5A5_0000);

    rst_n              = 1'b0;
    pc_select          = 1'b0;
    pc_target          = '0;
    stall              = 1'b0;
    flush_fetch_decode = 1'b0;
    imem_req_ready     = 1'b1;
    imem_rsp_valid     = 1'b0;
    imem_rsp_data      = '0;

    // ---------------- reset values ----------------
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_fd_valid",  {31'd0, fd_valid},       32'd0);
    chk("rst_fd_instr",  fd_instr,                NOP);
    chk("rst_fd_pc",     fd_pc,                   32'h0);
    chk("rst_fd_pc4",    fd_pc_plus4,             32'h4);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched",  perf_fetched,  32'd0);
    chk("rst_perf_squashed", perf_squashed, 32'd0);
`endif
    rst_n = 1'b1;

    // ---------------- vector table ----------------
    for (int i = 0; i < NV; i++) begin
      stall              = vecs[i].stall;
      flush_fetch_decode = vecs[i].flush;
      pc_select          = vecs[i].sel;
      pc_target          = vecs[i].target;
      imem_req_ready     = vecs[i].ready;
      cur_lat            = vecs[i].lat;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].e_rv});
      if (vecs[i].e_rv)
        chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_ra);
      chk($sformatf("v%0d_fd_valid", i), {31'd0, fd_valid}, {31'd0, vecs[i].e_fv});
      chk($sformatf("v%0d_fd_pc", i),    fd_pc,       vecs[i].e_pc);
      chk($sformatf("v%0d_fd_pc4", i),   fd_pc_plus4, vecs[i].e_pc + 32'd4);
      chk($sformatf("v%0d_fd_instr", i), fd_instr,    vecs[i].e_ins);
`ifdef FETCH_PERF_CNT_EN
      if (i == 22) chk("perf_squashed_before_flush", perf_squashed, 32'd2);
      if (i == 23) chk("perf_squashed_after_flush",  perf_squashed, 32'd3);
`endif
      cycle();
    end
    stall              = 1'b0;
    flush_fetch_decode = 1'b0;
    pc_select          = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_total",  perf_fetched,  32'd7);
    chk("perf_squashed_total", perf_squashed, 32'd3);
`endif

    // ---------------- reset mid-operation (WAIT with response pending) -----
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("midrst_fd_valid",  {31'd0, fd_valid},       32'd0);
    chk("midrst_fd_instr",  fd_instr,                NOP);
    chk("midrst_fd_pc",     fd_pc,                   32'h0);
    chk("midrst_fd_pc4",    fd_pc_plus4,             32'h4);
    mem_pend = 1'b0;
    @(posedge clk);
    #1;
    // Release with a stray response on the bus; it must be ignored.
    rst_n          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_req_addr",  imem_req_addr,           32'h0);
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    chk("stray_fd_valid", {31'd0, fd_valid}, 32'd0);
    chk("stray_fd_instr", fd_instr,          NOP);
    chk("stray_req_addr", imem_req_addr,     32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("stray_perf_fetched", perf_fetched, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
